// File: rtl/lsu_data_port.sv
// Load/store data port: turns one core request at a time into a single-cycle RAM access
// with a fixed-latency, registered completion pulse. Misaligned or illegal requests never reach the RAM.
module lsu_data_port #(
  parameter int unsigned ADDR_BITS = 22
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] data_addr,
  input  logic [31:0] data_rd,
  output logic [31:0] data_wr,
  output logic [3:0]  data_wr_en
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIssue  = 2'd1;
  localparam logic [1:0] StRdwait = 2'd2;
  localparam logic [1:0] StResp   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] data_addr_q, data_addr_d;
  logic [31:0] data_wr_q, data_wr_d;
  logic [3:0]  data_wr_en_q, data_wr_en_d;

  logic        req_illegal, req_misal;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] ld_lane, ld_data;
  logic        unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_BITS+2];

  // Request decode
  always_comb begin
    req_illegal = req_we ? (req_funct3 > 3'd2)
                         : (req_funct3 == 3'd3 || req_funct3 == 3'd6 || req_funct3 == 3'd7);
    req_misal   = (req_funct3[1:0] == 2'd1 && req_addr[0]) ||
                  (req_funct3[1:0] == 2'd2 && req_addr[1:0] != 2'd0);
    case (req_funct3[1:0])
      2'd0:    begin st_strb = 4'b0001 << req_addr[1:0]; st_data = {4{req_wdata[7:0]}};  end
      2'd1:    begin st_strb = 4'b0011 << req_addr[1:0]; st_data = {2{req_wdata[15:0]}}; end
      default: begin st_strb = 4'b1111;                  st_data = req_wdata;            end
    endcase
  end

  // Load extraction from the registered RAM word
  always_comb begin
    ld_lane = data_rd >> {off_q, 3'b000};
    case (f3_q[1:0])
      2'd0:    ld_data = {{24{~f3_q[2] & ld_lane[7]}}, ld_lane[7:0]};
      2'd1:    ld_data = {{16{~f3_q[2] & ld_lane[15]}}, ld_lane[15:0]};
      default: ld_data = ld_lane;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    off_d        = off_q;
    data_addr_d  = data_addr_q;
    data_wr_d    = data_wr_q;
    data_wr_en_d = 4'b0000;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = 32'h0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d  = req_we;
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          if (req_illegal || req_misal) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            state_d     = StResp;
          end else begin
            data_addr_d = {{(32-ADDR_BITS){1'b0}}, req_addr[ADDR_BITS+1:2]};
            if (req_we) begin
              data_wr_en_d = st_strb;
              data_wr_d    = st_data;
            end
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (we_q) begin
          rsp_valid_d = 1'b1;
          state_d     = StResp;
        end else begin
          state_d = StRdwait;
        end
      end
      StRdwait: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
        state_d     = StResp;
      end
      default: state_d = StIdle;
    endcase
    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      ready_q      <= 1'b1;
      we_q         <= 1'b0;
      f3_q         <= 3'd0;
      off_q        <= 2'd0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 32'h0;
      data_addr_q  <= 32'h0;
      data_wr_q    <= 32'h0;
      data_wr_en_q <= 4'b0000;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      data_addr_q  <= data_addr_d;
      data_wr_q    <= data_wr_d;
      data_wr_en_q <= data_wr_en_d;
    end
  end

  // ready_q resets high so the port is ready in the first cycle after release
  assign req_ready  = ready_q & resetn;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign data_addr  = data_addr_q;
  assign data_wr    = data_wr_q;
  assign data_wr_en = data_wr_en_q;

endmodule

// File: tb/tb_lsu_data_port.sv
// Bench for lsu_data_port: a 16-word RAM, a transaction-level reference model checked
// every cycle, directed cases with literal expectations, then randomized traffic with resets.
module tb_lsu_data_port;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] data_addr;
  logic [31:0] data_rd;
  logic [31:0] data_wr;
  logic [3:0]  data_wr_en;

  always #5 clk = ~clk;

  lsu_data_port #(.ADDR_BITS(22)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .data_addr  (data_addr),
    .data_rd    (data_rd),
    .data_wr    (data_wr),
    .data_wr_en (data_wr_en)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Synchronous RAM seen by the DUT
  logic [31:0] ram [16];
  logic        ram_clr_done = 1'b0;
  always @(posedge clk) begin
    if (!ram_clr_done) begin
      for (int i = 0; i < 16; i++) ram[i] <= 32'h0;
      data_rd      <= 32'h0;
      ram_clr_done <= 1'b1;
    end else begin
      data_rd <= ram[data_addr[3:0]];
      for (int i = 0; i < 4; i++)
        if (data_wr_en[i]) ram[data_addr[3:0]][8*i +: 8] <= data_wr[8*i +: 8];
    end
  end

  // Reference model: one outstanding transaction, tracked by cycle numbers
  logic [31:0] ref_mem [16];
  int          cyc = 0, resp_at = -1, idle_at = 0, wr_cyc = -1;
  logic        exp_err = 1'b0;
  logic [31:0] exp_rdata = 32'h0, exp_wdata = 32'h0, exp_waddr = 32'h0;
  logic [3:0]  exp_strb = 4'h0;
  logic        model_init = 1'b0;

  always @(posedge clk or negedge resetn) begin
    int          prev, nbytes, lat;
    logic        ill, mis;
    logic [31:0] w, v;
    if (!model_init) begin
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
      model_init = 1'b1;
    end
    if (!resetn) begin
      resp_at = -1;
      idle_at = 0;
      wr_cyc  = -1;
    end else begin
      prev = cyc;
      cyc  = cyc + 1;
      if (cyc == wr_cyc + 1)
        for (int i = 0; i < 4; i++)
          if (exp_strb[i]) ref_mem[exp_waddr[3:0]][8*i +: 8] = exp_wdata[8*i +: 8];
      if (prev >= idle_at && req_valid) begin
        ill = req_we ? (req_funct3 > 3'd2) : (req_funct3 == 3'd3 || req_funct3 >= 3'd6);
        nbytes = 1 << req_funct3[1:0];
        mis = (nbytes == 2 || nbytes == 4) && (req_addr % nbytes != 0);
        exp_err   = ill || mis;
        exp_rdata = 32'h0;
        if (exp_err) lat = 1;
        else if (req_we) begin
          lat       = 2;
          wr_cyc    = cyc;
          exp_waddr = req_addr >> 2;
          exp_strb  = 4'(((1 << nbytes) - 1) << req_addr[1:0]);
          if (nbytes == 1)      exp_wdata = req_wdata[7:0] * 32'h01010101;
          else if (nbytes == 2) exp_wdata = req_wdata[15:0] * 32'h00010001;
          else                  exp_wdata = req_wdata;
        end else begin
          lat = 3;
          w = ref_mem[req_addr[5:2]] >> (8 * req_addr[1:0]);
          v = (nbytes == 4) ? w : w % (32'h1 << (8 * nbytes));
          if (!req_funct3[2] && nbytes < 4 && v >= (32'h1 << (8 * nbytes - 1)))
            v = v - (32'h1 << (8 * nbytes));
          exp_rdata = v;
        end
        resp_at = cyc + lat - 1;
        idle_at = cyc + lat;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      if (!resetn) begin
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_err", {31'h0, rsp_err}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_wr", data_wr, 32'h0);
        chk("rst_wr_en", {28'h0, data_wr_en}, 32'h0);
      end else begin
        chk("ready", {31'h0, req_ready}, {31'h0, cyc >= idle_at});
        chk("valid", {31'h0, rsp_valid}, {31'h0, cyc == resp_at});
        chk("err", {31'h0, rsp_err}, {31'h0, cyc == resp_at && exp_err});
        if (cyc == resp_at) chk("rdata", rsp_rdata, exp_rdata);
        chk("wr_en", {28'h0, data_wr_en}, (cyc == wr_cyc) ? {28'h0, exp_strb} : 32'h0);
        if (cyc == wr_cyc) begin
          chk("wr_addr", data_addr, exp_waddr);
          for (int i = 0; i < 4; i++)
            if (exp_strb[i]) chk("wr_lane", {24'h0, data_wr[8*i +: 8]}, {24'h0, exp_wdata[8*i +: 8]});
        end
      end
    end
  end

  // Directed request: waits for ready, issues, returns result and latency in edges
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] strb_lit,
                        output logic [31:0] rd, output logic er, output int lat);
    int k;
    rd = 32'h0; er = 1'b0; lat = 0;
    @(negedge clk);
    for (k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'd7; req_addr = 32'h3f; req_wdata = ~wd;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) chk("strobe_lit", {28'h0, data_wr_en}, {28'h0, strb_lit});
      if (rsp_valid) begin
        rd = rsp_rdata; er = rsp_err; lat = k;
        break;
      end
    end
    if (lat == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_timeout: got no rsp_valid want one within 10 cycles");
    end
  endtask

  logic [31:0] lb_exp [4] = '{32'hFFFFFFC0, 32'hFFFFFFB0, 32'hFFFFFFA0, 32'hFFFFFF90};

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    #1 resetn = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'h1);

    do_req(1'b1, 3'd2, 32'h0, 32'hFFFFFFFF, 4'b1111, rd, er, lat);
    do_req(1'b1, 3'd0, 32'h1, 32'h01, 4'b0010, rd, er, lat);
    chk("sb_lat", lat, 2);
    @(negedge clk);
    chk("sb_mem", ram[0], 32'hFFFF01FF);
    do_req(1'b1, 3'd2, 32'h0, 32'hFFFFFFFF, 4'b1111, rd, er, lat);
    do_req(1'b1, 3'd1, 32'h2, 32'h0001, 4'b1100, rd, er, lat);
    @(negedge clk);
    chk("sh_mem", ram[0], 32'h0001FFFF);
    do_req(1'b1, 3'd2, 32'h0, 32'h1, 4'b1111, rd, er, lat);
    @(negedge clk);
    chk("sw_mem", ram[0], 32'h00000001);

    do_req(1'b1, 3'd2, 32'h0, 32'h90A0B0C0, 4'b1111, rd, er, lat);
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 3'd0, i, 32'h0, 4'b0000, rd, er, lat);
      chk("lb_data", rd, lb_exp[i]);
      chk("lb_lat", lat, 3);
    end
    do_req(1'b0, 3'd4, 32'h3, 32'h0, 4'b0000, rd, er, lat);
    chk("lbu_data", rd, 32'h00000090);
    do_req(1'b1, 3'd2, 32'h0, 32'h91A1B1C1, 4'b1111, rd, er, lat);
    do_req(1'b0, 3'd1, 32'h0, 32'h0, 4'b0000, rd, er, lat);
    chk("lh_data", rd, 32'hFFFFB1C1);
    do_req(1'b0, 3'd5, 32'h2, 32'h0, 4'b0000, rd, er, lat);
    chk("lhu_data", rd, 32'h000091A1);
    do_req(1'b1, 3'd2, 32'h0, 32'h92A2B2C2, 4'b1111, rd, er, lat);
    do_req(1'b0, 3'd2, 32'h0, 32'h0, 4'b0000, rd, er, lat);
    chk("lw_data", rd, 32'h92A2B2C2);

    do_req(1'b0, 3'd2, 32'h2, 32'h0, 4'b0000, rd, er, lat);
    chk("lw_mis_err", {31'h0, er}, 32'h1); chk("lw_mis_rd", rd, 32'h0); chk("lw_mis_lat", lat, 1);
    do_req(1'b1, 3'd1, 32'h3, 32'hABCD, 4'b0000, rd, er, lat);
    chk("sh_mis_err", {31'h0, er}, 32'h1); chk("sh_mis_lat", lat, 1);
    do_req(1'b0, 3'd3, 32'h0, 32'h0, 4'b0000, rd, er, lat);
    chk("ill_err", {31'h0, er}, 32'h1); chk("ill_rd", rd, 32'h0);
    @(negedge clk);
    chk("err_mem", ram[0], 32'h92A2B2C2);

    // Reset between E0 and E1 of a store
    @(negedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h0; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); #1;
    resetn = 1'b0;
    #1 chk("abort_wr_en", {28'h0, data_wr_en}, 32'h0);
    repeat (2) @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("abort_ready", {31'h0, req_ready}, 32'h1);
    chk("abort_mem", ram[0], 32'h92A2B2C2);

    // Randomized traffic, including requests driven while busy and occasional resets
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      if ($urandom_range(0, 399) == 0) begin
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
      end else begin
        req_valid = ($urandom_range(0, 3) != 0);
        req_we    = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 7) == 0) req_funct3 = 3'($urandom_range(0, 7));
        else if (req_we) req_funct3 = 3'($urandom_range(0, 2));
        else begin
          req_funct3 = 3'($urandom_range(0, 4));
          if (req_funct3 > 3'd2) req_funct3 = req_funct3 + 3'd1;
        end
        req_addr  = $urandom_range(0, 63);
        if ($urandom_range(0, 1) == 1) req_addr[1:0] = 2'b00;
        req_wdata = $urandom;
      end
    end
    @(negedge clk); #1 req_valid = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16; i++) chk("final_mem", ram[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
